tmds_channel_decoder: RTL and testbench
=======================================

// Module: tmds_channel_decoder
// PURPOSE
//  Receive-side counterpart of the character display's TMDS transmit path: one HDMI/DVI TMDS
//  channel, pixel-clock domain. Takes raw 10-bit words from an upstream deserializer whose
//  word boundary is arbitrary, finds the boundary using control tokens sent during blanking,
//  and decodes the aligned words back into 8-bit pixel data or 2-bit control values with a
//  data-enable flag. Instantiate one per channel (0 = blue, which also carries HSYNC/VSYNC).
// PARAMETERS
//  SLIP_DWELL   1024  cycles spent at one bit offset with no token before slipping (> active line)
//  LOCK_TOKENS  16    consecutive aligned tokens needed to declare lock
//  LOSS_TIMEOUT 2048  cycles without any token while locked before lock is dropped
// PORTS
//  clk         in   1   pixel clock; all logic on rising edge
//  rst         in   1   synchronous, active-low reset
//  tmds_in     in   10  raw deserialized word; bit 0 = first bit on the wire
//  pix_data    out  8   decoded pixel byte (valid when de=1)
//  ctrl        out  2   decoded control value {C1,C0}; holds last token value while de=1
//  de          out  1   1 = pix_data valid (data period), 0 = control period or not locked
//  locked      out  1   word alignment locked
//  bit_offset  out  4   current alignment offset, 0..9
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state=SEARCH, bit_offset=0, all counters 0, pix_data=0,
//   ctrl=0, de=0, locked=0, internal word registers 0.
//  Alignment: raw_q <= tmds_in each cycle; window = {tmds_in, raw_q}[bit_offset +: 10];
//   word_q <= window (stage 1). Offset changes take effect on the next window.
//  Tokens (on word_q): 10'b1101010100=00, 10'b0010101011=01, 10'b0101010100=10,
//   10'b1010101011=11. Any other value is a data word.
//  FSM (evaluated on word_q each cycle):
//   SEARCH: token -> VERIFY, tok_cnt=1. Else dwell+1; at dwell==SLIP_DWELL-1:
//    bit_offset = (bit_offset==9) ? 0 : bit_offset+1, dwell=0.
//   VERIFY: token -> tok_cnt+1; at tok_cnt==LOCK_TOKENS-1 -> LOCKED. Non-token -> SEARCH,
//    dwell=0, offset kept (no slip).
//   LOCKED: locked=1. Token -> loss_cnt=0. Non-token -> loss_cnt+1; at
//    loss_cnt==LOSS_TIMEOUT-1 -> SEARCH, dwell=0, offset kept. Data words never break lock.
//  Decode (stage 2, registered from word_q, q=word_q):
//   d = q[9] ? ~q[7:0] : q[7:0]; out[0]=d[0];
//   out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]), i=1..7.
//   Token: de<=0, ctrl<=token value, pix_data<=0. Data: de<=1, pix_data<=out, ctrl held.
//  Latency: word presented on tmds_in at cycle t (offset 0) appears on outputs after edge t+2.
//  Gating: while locked=0 (registered alongside stage 2): de=0, pix_data=0, ctrl=0.
//  locked rises on the same edge as the stage-2 update of the LOCK_TOKENS-th token.
//  Reset mid-operation: full return to reset state on the next edge, regardless of FSM state.
//  No disparity checking; invalid data codes decode per formula without error flag.
// TESTING
//  1 Aligned token stream (0x354 repeated), offset 0 -> locked=1 after 16 tokens + 2 cycles
//    latency, bit_offset=0, de=0, ctrl=2'b00.
//  2 Same serial stream skewed by 3 bits, 0x2AB/0x154 tokens -> slips every 1024 cycles,
//    locks at bit_offset=3 (or 7 for the rotated framing), ctrl tracks tokens.
//  3 Locked, send 0x100, 0x0FF, 0x200 -> two cycles later pix_data=0x00,0xFF,0xFF with de=1;
//    next token -> de=0.
//  4 Locked, 2048 consecutive data words -> locked drops on the 2048th, de=0, state SEARCH,
//    bit_offset unchanged; tokens resume -> relock after 16.
//  5 VERIFY interrupted: 10 tokens, 1 data word, 16 tokens -> no lock after the first 10,
//    lock after the final 16, no offset change.
//  6 rst=0 for one cycle while locked and de=1 -> next edge: all outputs 0, bit_offset=0.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_channel_decoder
//  Description : One TMDS receive channel. Finds the 10-bit word boundary from
//                blanking-period control tokens, then decodes aligned words
//                into pixel bytes or control values with a data-enable flag.
//  Revision    : 1.0  initial release
// ============================================================================
module tmds_channel_decoder #(
    parameter int SLIP_DWELL   = 1024,
    parameter int LOCK_TOKENS  = 16,
    parameter int LOSS_TIMEOUT = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] tmds_in,
    output logic [7:0] pix_data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] bit_offset
);

    localparam int DW = (SLIP_DWELL   > 1) ? $clog2(SLIP_DWELL)   : 1;
    localparam int TW = (LOCK_TOKENS  > 1) ? $clog2(LOCK_TOKENS)  : 1;
    localparam int LW = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(SLIP_DWELL - 1);
    localparam logic [TW-1:0] TOK_LAST   = TW'(LOCK_TOKENS - 1);
    localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_TIMEOUT - 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [9:0]    raw_q, word_q, window_w;
    logic [19:0]   cat_w;
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [TW-1:0] tok_q, tok_d;
    logic [LW-1:0] loss_q, loss_d;
    logic [3:0]    offset_q, offset_d;
    logic [7:0]    pix_q, pix_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          de_q, de_d;
    logic          locked_q, locked_d;
    logic          tok_hit_w;
    logic [1:0]    tok_val_w;
    logic [7:0]    d_w, dec_w;

    // Older word occupies the low half, so offset k starts k bits into the stream.
    assign cat_w = {tmds_in, raw_q};

    always_comb begin
        window_w = raw_q;
        case (offset_q)
            4'd1:    window_w = cat_w[10:1];
            4'd2:    window_w = cat_w[11:2];
            4'd3:    window_w = cat_w[12:3];
            4'd4:    window_w = cat_w[13:4];
            4'd5:    window_w = cat_w[14:5];
            4'd6:    window_w = cat_w[15:6];
            4'd7:    window_w = cat_w[16:7];
            4'd8:    window_w = cat_w[17:8];
            4'd9:    window_w = cat_w[18:9];
            default: window_w = raw_q;
        endcase
    end

    always_comb begin
        tok_hit_w = 1'b1;
        tok_val_w = 2'b00;
        case (word_q)
            10'b1101010100: tok_val_w = 2'b00;
            10'b0010101011: tok_val_w = 2'b01;
            10'b0101010100: tok_val_w = 2'b10;
            10'b1010101011: tok_val_w = 2'b11;
            default:        tok_hit_w = 1'b0;
        endcase
    end

    always_comb begin
        d_w      = word_q[9] ? ~word_q[7:0] : word_q[7:0];
        dec_w    = 8'h00;
        dec_w[0] = d_w[0];
        for (int i = 1; i < 8; i++) begin
            dec_w[i] = word_q[8] ? (d_w[i] ^ d_w[i-1]) : ~(d_w[i] ^ d_w[i-1]);
        end
    end

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        tok_d    = tok_q;
        loss_d   = loss_q;
        offset_d = offset_q;
        case (state_q)
            ST_SEARCH: begin
                if (tok_hit_w) begin
                    state_d = ST_VERIFY;
                    tok_d   = TW'(1);
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d  = '0;
                    offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ST_VERIFY: begin
                if (tok_hit_w) begin
                    if (tok_q == TOK_LAST) begin
                        state_d = ST_LOCKED;
                        loss_d  = '0;
                    end else begin
                        tok_d = tok_q + TW'(1);
                    end
                end else begin
                    // A broken token run retries at the same offset rather than slipping.
                    state_d = ST_SEARCH;
                    dwell_d = '0;
                end
            end
            ST_LOCKED: begin
                if (tok_hit_w) begin
                    loss_d = '0;
                end else if (loss_q == LOSS_LAST) begin
                    state_d = ST_SEARCH;
                    dwell_d = '0;
                end else begin
                    loss_d = loss_q + LW'(1);
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        locked_d = (state_d == ST_LOCKED);
        de_d     = 1'b0;
        pix_d    = 8'h00;
        ctrl_d   = 2'b00;
        if (locked_d) begin
            if (tok_hit_w) begin
                ctrl_d = tok_val_w;
            end else begin
                de_d   = 1'b1;
                pix_d  = dec_w;
                ctrl_d = ctrl_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            raw_q    <= '0;
            word_q   <= '0;
            state_q  <= ST_SEARCH;
            dwell_q  <= '0;
            tok_q    <= '0;
            loss_q   <= '0;
            offset_q <= '0;
            pix_q    <= '0;
            ctrl_q   <= '0;
            de_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            raw_q    <= tmds_in;
            word_q   <= window_w;
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            tok_q    <= tok_d;
            loss_q   <= loss_d;
            offset_q <= offset_d;
            pix_q    <= pix_d;
            ctrl_q   <= ctrl_d;
            de_q     <= de_d;
            locked_q <= locked_d;
        end
    end

    assign pix_data   = pix_q;
    assign ctrl       = ctrl_q;
    assign de         = de_q;
    assign locked     = locked_q;
    assign bit_offset = offset_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmds_channel_decoder
//  Description : Directed, table-driven bench for tmds_channel_decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tmds_channel_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] tmds_in = 10'h000;
    logic [7:0] pix_data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] bit_offset;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [9:0] w;
        logic       de;
        logic [7:0] pix;
        logic [1:0] ctrl;
    } vec_t;

    vec_t vt[13];

    tmds_channel_decoder #(
        .SLIP_DWELL  (1024),
        .LOCK_TOKENS (16),
        .LOSS_TIMEOUT(2048)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tmds_in   (tmds_in),
        .pix_data  (pix_data),
        .ctrl      (ctrl),
        .de        (de),
        .locked    (locked),
        .bit_offset(bit_offset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        tmds_in = 10'h000;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Presents a serial token/data stream whose word boundary sits 3 bits late.
    task automatic skew_seq(input logic [9:0] a, input int na, input logic [9:0] b, input int nb);
        logic [9:0] cur;
        logic [9:0] nxt;
        for (int i = 0; i < na + nb; i++) begin
            cur     = (i < na) ? a : b;
            nxt     = (i + 1 < na) ? a : b;
            tmds_in = {nxt[6:0], cur[9:7]};
            tick();
        end
    endtask

    initial begin
        logic [9:0] skw;
        logic       seen;

        vt[0]  = '{10'h100, 1'b1, 8'h00, 2'b00};
        vt[1]  = '{10'h0FF, 1'b1, 8'hFF, 2'b00};
        vt[2]  = '{10'h200, 1'b1, 8'hFF, 2'b00};
        vt[3]  = '{10'h354, 1'b0, 8'h00, 2'b00};
        vt[4]  = '{10'h0AB, 1'b0, 8'h00, 2'b01};
        vt[5]  = '{10'h155, 1'b1, 8'hFF, 2'b01};
        vt[6]  = '{10'h154, 1'b0, 8'h00, 2'b10};
        vt[7]  = '{10'h1FF, 1'b1, 8'h01, 2'b10};
        vt[8]  = '{10'h3F0, 1'b1, 8'h11, 2'b10};
        vt[9]  = '{10'h2AB, 1'b0, 8'h00, 2'b11};
        vt[10] = '{10'h0F0, 1'b1, 8'hEE, 2'b11};
        vt[11] = '{10'h001, 1'b1, 8'hFD, 2'b11};
        vt[12] = '{10'h354, 1'b0, 8'h00, 2'b00};

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk("rst_outputs", {23'd0, pix_data, ctrl, de, locked, bit_offset}, 32'd0);
        rst = 1'b1;

        // Aligned token stream at offset 0
        for (int m = 0; m <= 17; m++) begin
            tmds_in = 10'h354;
            tick();
            if (m == 16) chk("t1_prelock", locked, 0);
        end
        chk("t1_locked", locked, 1);
        chk("t1_offset", bit_offset, 0);
        chk("t1_de_ctrl", {de, ctrl}, 3'b000);

        // Decode table, outputs lag input by two edges
        for (int i = 0; i < 15; i++) begin
            tmds_in = (i < 13) ? vt[i].w : 10'h354;
            tick();
            if (i >= 2)
                chk($sformatf("t3_vec%0d", i - 2), {de, pix_data, ctrl},
                    {vt[i-2].de, vt[i-2].pix, vt[i-2].ctrl});
        end
        chk("t3_locked", locked, 1);

        // Loss of lock after 2048 data words
        for (int j = 0; j < 2050; j++) begin
            tmds_in = 10'h100;
            tick();
            if (j == 2048) chk("t4_still_locked", {locked, de}, 2'b11);
        end
        chk("t4_dropped", {locked, de, pix_data, ctrl}, 11'd0);
        chk("t4_offset", bit_offset, 0);
        for (int m = 0; m <= 17; m++) begin
            tmds_in = 10'h354;
            tick();
            if (m == 16) chk("t4_prerelock", locked, 0);
        end
        chk("t4_relocked", locked, 1);

        // VERIFY interrupted by a single data word
        do_reset();
        seen = 1'b0;
        for (int m = 0; m <= 28; m++) begin
            tmds_in = (m == 10) ? 10'h100 : 10'h354;
            tick();
            if (m < 28 && locked) seen = 1'b1;
        end
        chk("t5_no_early_lock", seen, 0);
        chk("t5_locked", locked, 1);
        chk("t5_offset", bit_offset, 0);

        // Skewed stream: slip every 1024 cycles, lock at offset 3
        do_reset();
        skw = {10'h2AB & 10'h07F, 3'b000} | {7'd0, 3'b101};
        skw = {7'b0101011, 3'b101};
        for (int n = 0; n < 6000; n++) begin
            tmds_in = skw;
            tick();
            if (n == 1022) chk("t2_before_slip", bit_offset, 0);
            if (n == 1023) chk("t2_first_slip", bit_offset, 1);
            if (locked) break;
        end
        chk("t2_locked", locked, 1);
        chk("t2_offset", bit_offset, 3);
        chk("t2_ctrl11", {de, ctrl}, 3'b011);
        skew_seq(10'h2AB, 4, 10'h154, 8);
        chk("t2_ctrl10", {locked, de, ctrl, bit_offset}, {1'b1, 1'b0, 2'b10, 4'd3});
        skew_seq(10'h154, 1, 10'h0FF, 6);
        chk("t2_data", {locked, de, pix_data, ctrl}, {1'b1, 1'b1, 8'hFF, 2'b10});

        // Reset while locked with de high
        rst = 1'b0;
        tick();
        chk("t6_reset", {23'd0, pix_data, ctrl, de, locked, bit_offset}, 32'd0);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
